sum_sequencer: RTL and testbench

//   Control FSM and datapath for the sum display: captures num on a start press,

---
 rtl/sum_sequencer.sv | 128 ++++++++++++
 tb/tb_sum_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_sequencer.sv
// Sum sequencer: captures a target on a start press, then on each tick adds the
// next integer into a saturating accumulator that feeds the 3-digit display.
//
// state | meaning
// IDLE  | waiting for a start press
// LOAD  | one cycle: sample num, clear count/accum/overflow
// RUN   | each tick adds count+1 into accum until target terms are summed
// DONE  | result held; a new start press begins another run
module sum_sequencer #(
    parameter int N_W      = 6,
    parameter int ACC_W    = 10,
    parameter int MAX_DISP = 999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    input  logic [N_W-1:0]   num,
    output logic [N_W-1:0]   count,
    output logic [ACC_W-1:0] accum,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [1:0]       status_led
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_DISP);

    state_t           state, state_nxt;
    logic [N_W-1:0]   target, target_nxt;
    logic [N_W-1:0]   count_nxt, count_inc;
    logic [ACC_W-1:0] accum_nxt;
    logic             overflow_nxt;
    logic [ACC_W:0]   sum;
    logic             start_q1, start_q2, start_q3;
    logic             start_rise;

    // q1/q2 resolve metastability; q3 remembers the previous level for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q1 <= 1'b0;
            start_q2 <= 1'b0;
            start_q3 <= 1'b0;
        end else begin
            start_q1 <= start;
            start_q2 <= start_q1;
            start_q3 <= start_q2;
        end
    end

    assign start_rise = start_q2 & ~start_q3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            target   <= '0;
            count    <= '0;
            accum    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            count    <= count_nxt;
            accum    <= accum_nxt;
            overflow <= overflow_nxt;
        end
    end

    assign count_inc = count + 1'b1;
    // one extra bit so accum + (count+1) cannot wrap before the saturation compare
    assign sum = {1'b0, accum} + {{(ACC_W + 1 - N_W){1'b0}}, count_inc};

    always_comb begin
        state_nxt    = state;
        target_nxt   = target;
        count_nxt    = count;
        accum_nxt    = accum;
        overflow_nxt = overflow;
        case (state)
            IDLE: begin
                if (start_rise) state_nxt = LOAD;
            end
            LOAD: begin
                target_nxt   = num;
                count_nxt    = '0;
                accum_nxt    = '0;
                overflow_nxt = 1'b0;
                state_nxt    = (num == '0) ? DONE : RUN;
            end
            RUN: begin
                if (tick) begin
                    count_nxt = count_inc;
                    if (sum > {1'b0, MAX_ACC}) begin
                        accum_nxt    = MAX_ACC;
                        overflow_nxt = 1'b1;
                    end else begin
                        accum_nxt = sum[ACC_W-1:0];
                    end
                    if (count_inc == target) state_nxt = DONE;
                end
            end
            DONE: begin
                if (start_rise) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt    = IDLE;
            count_nxt    = '0;
            accum_nxt    = '0;
            overflow_nxt = 1'b0;
        end
    end

    assign busy       = (state == LOAD) || (state == RUN);
    assign done       = (state == DONE);
    assign status_led = (state == DONE) ? {1'b1, overflow} :
                        busy            ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_sum_sequencer.sv
// Directed bench for sum_sequencer: a table of complete runs plus hand-written
// sequences for latency, saturation, held start, abort priority and async reset.
module tb_sum_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [5:0] num = '0;
    logic [5:0] count;
    logic [9:0] accum;
    logic       busy, done, overflow;
    logic [1:0] status_led;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int num;
        int ticks;
        int acc;
        int cnt;
        int dn;
        int ovf;
        int led;
    } vec_t;

    vec_t vecs[8];

    sum_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .abort(abort),
        .num(num), .count(count), .accum(accum), .busy(busy), .done(done),
        .overflow(overflow), .status_led(status_led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // start high for 4 edges: sync (2), LOAD entered (3rd), LOAD exits (4th)
    task automatic press();
        start = 1'b1;
        repeat (4) step();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    initial begin
        int exp_a[4];
        vecs[0] = '{4, 4, 10, 4, 1, 0, 2};
        vecs[1] = '{0, 0, 0, 0, 1, 0, 2};
        vecs[2] = '{45, 45, 999, 45, 1, 1, 3};
        vecs[3] = '{10, 10, 55, 10, 1, 0, 2};
        vecs[4] = '{63, 63, 999, 63, 1, 1, 3};
        vecs[5] = '{5, 3, 6, 3, 0, 0, 1};
        vecs[6] = '{44, 44, 990, 44, 1, 0, 2};
        vecs[7] = '{1, 1, 1, 1, 1, 0, 2};
        exp_a = '{1, 3, 6, 10};

        // reset state
        repeat (3) step();
        chk("rst_count", count, 0);
        chk("rst_accum", accum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_led", status_led, 0);
        rst = 1'b1;
        step();

        for (int v = 0; v < 8; v++) begin
            do_abort();
            chk("tbl_idle_busy", busy, 0);
            num = vecs[v].num[5:0];
            press();
            tick_n(vecs[v].ticks);
            chk($sformatf("tbl%0d_accum", v), accum, vecs[v].acc);
            chk($sformatf("tbl%0d_count", v), count, vecs[v].cnt);
            chk($sformatf("tbl%0d_done", v), done, vecs[v].dn);
            chk($sformatf("tbl%0d_ovf", v), overflow, vecs[v].ovf);
            chk($sformatf("tbl%0d_led", v), status_led, vecs[v].led);
        end

        // per-tick accumulation; num changed mid-run must not matter
        do_abort();
        num = 6'd4;
        press();
        chk("a_busy", busy, 1);
        chk("a_count0", count, 0);
        num = 6'd9;
        for (int i = 0; i < 4; i++) begin
            tick_n(1);
            chk($sformatf("a_accum_t%0d", i + 1), accum, exp_a[i]);
        end
        chk("a_done", done, 1);
        chk("a_led", status_led, 2);

        // num=0: LOAD for one cycle then DONE without any tick
        do_abort();
        num = 6'd0;
        start = 1'b1;
        repeat (3) step();
        chk("z_load_busy", busy, 1);
        chk("z_load_done", done, 0);
        step();
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_accum", accum, 0);
        start = 1'b0;

        // saturation boundary: 990 fits, 990+45 clamps; count keeps advancing
        do_abort();
        num = 6'd50;
        press();
        tick_n(44);
        chk("s_accum44", accum, 990);
        chk("s_ovf44", overflow, 0);
        chk("s_led44", status_led, 1);
        tick_n(1);
        chk("s_accum45", accum, 999);
        chk("s_ovf45", overflow, 1);
        tick_n(5);
        chk("s_accum50", accum, 999);
        chk("s_count50", count, 50);
        chk("s_led50", status_led, 3);
        do_abort();
        chk("s_abort_ovf", overflow, 0);
        chk("s_abort_led", status_led, 0);

        // held start, re-press during RUN ignored, restart from DONE
        do_abort();
        num = 6'd10;
        start = 1'b1;
        repeat (4) step();
        chk("h_busy", busy, 1);
        for (int i = 1; i <= 10; i++) begin
            start = (i >= 4 && i <= 6) ? 1'b0 : 1'b1;
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        chk("h_accum", accum, 55);
        chk("h_count", count, 10);
        chk("h_done", done, 1);
        repeat (5) step();
        chk("h_hold_done", done, 1);
        chk("h_hold_accum", accum, 55);
        start = 1'b0;
        repeat (3) step();
        num = 6'd3;
        start = 1'b1;
        repeat (3) step();
        chk("h_reload_busy", busy, 1);
        step();
        chk("h_restart_accum", accum, 0);
        chk("h_restart_count", count, 0);
        start = 1'b0;
        tick_n(3);
        chk("h_rerun_accum", accum, 6);
        chk("h_rerun_done", done, 1);

        // abort beats tick in RUN, and beats start_rise in IDLE
        do_abort();
        num = 6'd20;
        press();
        tick_n(5);
        chk("ab_accum5", accum, 15);
        abort = 1'b1;
        tick = 1'b1;
        step();
        abort = 1'b0;
        tick = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_accum", accum, 0);
        chk("ab_count", count, 0);
        chk("ab_led", status_led, 0);
        start = 1'b1;
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_rise_busy", busy, 0);
        repeat (3) step();
        chk("ab_held_busy", busy, 0);
        start = 1'b0;

        // async reset between edges, then tick alone does nothing
        do_abort();
        num = 6'd20;
        press();
        tick_n(3);
        chk("r_accum3", accum, 6);
        #2 rst = 1'b0;
        #1;
        chk("r_accum", accum, 0);
        chk("r_count", count, 0);
        chk("r_busy", busy, 0);
        chk("r_led", status_led, 0);
        #3 rst = 1'b1;
        tick = 1'b1;
        repeat (5) step();
        tick = 1'b0;
        chk("r_post_busy", busy, 0);
        chk("r_post_accum", accum, 0);
        chk("r_post_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
